// File: rtl/ram8_access_ctrl_if.sv
// Request/response and RAM pin bundle for ram8_access_ctrl.
// The slave modport is the controller. The master modport is the requester plus the RAM side.
`timescale 1ns/1ps
interface ram8_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  // request port
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  // response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  // RAM_8 pins
  logic              ram_e;
  logic              ram_w;
  logic              ram_r;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_data, ram_e, ram_w, ram_r, ram_addr, ram_d
  );

  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_data, ram_e, ram_w, ram_r, ram_addr, ram_d
  );
endinterface

// File: rtl/ram8_access_ctrl.sv
// Single-request front-end for the 8x16 register-file RAM.
// It clears the RAM after reset (optional), runs one-cycle write and read accesses,
// and holds each read result until the consumer takes it.
`timescale 1ns/1ps
module ram8_access_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 3,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  ram8_access_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  // The last word of the sweep. The counter wraps back to 0 on the edge that leaves INIT.
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  req_t              req_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  // Sequence the controller. The response register is loaded only from READ,
  // so an undriven RAM output never reaches rsp_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT_EN ? S_INIT : S_IDLE;
      cnt         <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            req_q.wr   <= bus.req_wr;
            req_q.addr <= bus.req_addr;
            req_q.data <= bus.req_data;
            state      <= bus.req_wr ? S_WRITE : S_READ;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_READ: begin
          rsp_data_q  <= bus.ram_q;
          rsp_valid_q <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decode the RAM pins from the state and the captured request.
  // W and R come from different states, so they are never both asserted.
  always_comb begin
    bus.ram_e    = 1'b0;
    bus.ram_w    = 1'b0;
    bus.ram_r    = 1'b0;
    bus.ram_addr = '0;
    bus.ram_d    = '0;
    case (state)
      S_INIT: begin
        bus.ram_e    = 1'b1;
        bus.ram_w    = 1'b1;
        bus.ram_addr = cnt;
        bus.ram_d    = INIT_VAL;
      end
      S_WRITE: begin
        bus.ram_e    = 1'b1;
        bus.ram_w    = 1'b1;
        bus.ram_addr = req_q.addr;
        bus.ram_d    = req_q.data;
      end
      S_READ: begin
        bus.ram_e    = 1'b1;
        bus.ram_r    = 1'b1;
        bus.ram_addr = req_q.addr;
      end
      default: ;
    endcase
  end

  // The controller accepts a request only in IDLE, so requests never queue behind an access.
  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram8_access_ctrl.sv
// Directed bench for ram8_access_ctrl with a behavioural RAM_8 on the pin side.
`timescale 1ns/1ps
module tb_ram8_access_ctrl;

  logic clk;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;
  int   wr_rd_both = 0;

  ram8_access_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  ram8_access_ctrl #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .INIT_EN (1'b1),
    .INIT_VAL(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural RAM_8. Its output is X unless E and R are both high.
  logic [15:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 16'hA5A5;
  always @(posedge clk)
    if (bus.ram_e && bus.ram_w) mem[bus.ram_addr] <= bus.ram_d;
  always_comb
    bus.ram_q = (bus.ram_e && bus.ram_r) ? mem[bus.ram_addr] : 16'hxxxx;

  // Catch any cycle with W and R high together.
  always @(negedge clk)
    if (bus.ram_w === 1'b1 && bus.ram_r === 1'b1) wr_rd_both++;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    chk("wr_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("wr_e",    bus.ram_e, 1);
    chk("wr_w",    bus.ram_w, 1);
    chk("wr_r",    bus.ram_r, 0);
    chk("wr_addr", bus.ram_addr, a);
    chk("wr_d",    bus.ram_d, d);
    tick();
    chk("wr_back_idle", bus.req_ready, 1);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input int hold);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = a;
    bus.req_data  = 16'hDEAD;
    chk("rd_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("rd_r",     bus.ram_r, 1);
    chk("rd_w",     bus.ram_w, 0);
    chk("rd_addr",  bus.ram_addr, a);
    chk("rd_nvld",  bus.rsp_valid, 0);
    tick();
    for (int c = 0; c < hold; c++) begin
      bus.req_valid = 1'b1;  // must be ignored while a response is pending
      chk("hold_vld",  bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, exp);
      chk("hold_rdy",  bus.req_ready, 0);
      chk("hold_e",    bus.ram_e, 0);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("rsp_vld",  bus.rsp_valid, 1);
    chk("rsp_data", bus.rsp_data, exp);
    chk("rsp_rdy",  bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_clr",  bus.rsp_valid, 0);
    chk("rsp_idle", bus.req_ready, 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_rsp_vld",  bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_req_rdy",  bus.req_ready, 0);
    repeat (2) tick();
    rst = 1'b0;

    // 1: clear sweep writes 0 to addresses 0..7, then IDLE
    for (int i = 0; i < 8; i++) begin
      chk("init_e",    bus.ram_e, 1);
      chk("init_w",    bus.ram_w, 1);
      chk("init_r",    bus.ram_r, 0);
      chk("init_addr", bus.ram_addr, i);
      chk("init_d",    bus.ram_d, 0);
      chk("init_rdy",  bus.req_ready, 0);
      tick();
    end
    chk("post_init_rdy", bus.req_ready, 1);
    chk("post_init_w",   bus.ram_w, 0);
    chk("post_init_e",   bus.ram_e, 0);

    // 2: write then read same address
    do_write(3'd5, 16'hBEEF);
    do_read(3'd5, 16'hBEEF, 0);

    // 3: unwritten address reads the cleared value
    do_read(3'd3, 16'h0000, 0);

    // 4: consumer stalls for 5 cycles
    do_read(3'd5, 16'hBEEF, 5);

    // 5: fill all words, read all back
    for (int i = 0; i < 8; i++) begin
      logic [15:0] v;
      v = 16'(16'h1111 * i);
      do_write(3'(i), v);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] v;
      v = 16'(16'h1111 * i);
      do_read(3'(i), v, 0);
    end
    chk("no_w_and_r", wr_rd_both, 0);

    // 6: reset during READ drops the request and re-clears the RAM
    do_write(3'd2, 16'h1234);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 3'd2;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_rd_r", bus.ram_r, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld",  bus.rsp_valid, 0);
    chk("mid_rst_w",    bus.ram_w, 1);
    chk("mid_rst_addr", bus.ram_addr, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("reinit_addr", bus.ram_addr, i);
      chk("reinit_w",    bus.ram_w, 1);
      chk("reinit_vld",  bus.rsp_valid, 0);
      tick();
    end
    do_read(3'd2, 16'h0000, 0);
    do_read(3'd7, 16'h0000, 0);
    chk("no_w_and_r_end", wr_rd_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
